// File: rtl/cand_pkg.sv
// Shared types and constants for the candidate memory bank and its scanner.
package cand_pkg;

   localparam int unsigned WORD_WIDTH   = 16;
   localparam int unsigned CAND_ID_MSB  = 15;
   localparam int unsigned CAND_ID_LSB  = 8;
   localparam int unsigned CAND_FIT_MSB = 7;
   localparam int unsigned CAND_FIT_LSB = 0;
   localparam int unsigned ID_W         = CAND_ID_MSB - CAND_ID_LSB + 1;
   localparam int unsigned FIT_W        = CAND_FIT_MSB - CAND_FIT_LSB + 1;

   localparam logic [ID_W-1:0] EMPTY_ID = 8'h00;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SCAN  = 2'd1,
      ST_CLEAR = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

endpackage

// File: rtl/candidate_scanner.sv
// Walks the candidate bank, picks the fittest occupied entry (lowest index on ties),
// counts occupied entries and optionally zero-fills the bank afterwards.
module candidate_scanner #(
   parameter int unsigned   WORD_WIDTH = cand_pkg::WORD_WIDTH,
   parameter int unsigned   NUM_WORDS  = 8,
   parameter logic [7:0]    EMPTY_ID   = cand_pkg::EMPTY_ID,
   localparam int unsigned  CNT_W      = $clog2(NUM_WORDS + 1)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic                  clear_req,
   output logic                  busy,
   output logic                  done,
   output logic                  found,
   output logic [7:0]            best_id,
   output logic [7:0]            best_fit,
   output logic [CNT_W-1:0]      cand_count,
   output logic                  mem_wr_en,
   output logic [WORD_WIDTH-1:0] mem_index,
   output logic [WORD_WIDTH-1:0] mem_wdata,
   input  logic [WORD_WIDTH-1:0] mem_rdata
);

   import cand_pkg::*;

   localparam int unsigned K_W    = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
   localparam logic [K_W-1:0] LAST_K = K_W'(NUM_WORDS - 1);

   state_t           state;
   logic [K_W-1:0]   k;
   logic             clr_lat;

   logic             w_found;
   logic [7:0]       w_id;
   logic [7:0]       w_fit;
   logic [CNT_W-1:0] w_count;

   logic             nxt_found;
   logic [7:0]       nxt_id;
   logic [7:0]       nxt_fit;
   logic [CNT_W-1:0] nxt_count;

   logic [7:0]       rd_id;
   logic [7:0]       rd_fit;
   logic             occupied;

   // Byte address of candidate word kk in the bank.
   function automatic logic [WORD_WIDTH-1:0] word_index(input logic [K_W-1:0] kk);
      return WORD_WIDTH'({kk, 1'b0});
   endfunction

   assign mem_wdata = '0;
   assign rd_id     = mem_rdata[CAND_ID_MSB:CAND_ID_LSB];
   assign rd_fit    = mem_rdata[CAND_FIT_MSB:CAND_FIT_LSB];
   assign occupied  = (rd_id != EMPTY_ID);

   // Working-best update for the word currently on the read port.
   always_comb begin
      nxt_found = w_found;
      nxt_id    = w_id;
      nxt_fit   = w_fit;
      nxt_count = w_count;
      if (occupied) begin
         nxt_count = w_count + CNT_W'(1);
         nxt_found = 1'b1;
         if (!w_found || (rd_fit > w_fit)) begin
            nxt_id  = rd_id;
            nxt_fit = rd_fit;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= ST_IDLE;
         k          <= '0;
         clr_lat    <= 1'b0;
         w_found    <= 1'b0;
         w_id       <= '0;
         w_fit      <= '0;
         w_count    <= '0;
         busy       <= 1'b0;
         done       <= 1'b0;
         found      <= 1'b0;
         best_id    <= '0;
         best_fit   <= '0;
         cand_count <= '0;
         mem_wr_en  <= 1'b0;
         mem_index  <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (start) begin
                  state     <= ST_SCAN;
                  clr_lat   <= clear_req;
                  w_found   <= 1'b0;
                  w_id      <= '0;
                  w_fit     <= '0;
                  w_count   <= '0;
                  k         <= '0;
                  mem_index <= '0;
                  busy      <= 1'b1;
               end
            end

            ST_SCAN: begin
               w_found <= nxt_found;
               w_id    <= nxt_id;
               w_fit   <= nxt_fit;
               w_count <= nxt_count;
               if (k == LAST_K) begin
                  k         <= '0;
                  mem_index <= '0;
                  if (clr_lat) begin
                     state     <= ST_CLEAR;
                     mem_wr_en <= 1'b1;
                  end else begin
                     // The last word's update must reach the results directly.
                     state      <= ST_DONE;
                     busy       <= 1'b0;
                     done       <= 1'b1;
                     found      <= nxt_found;
                     best_id    <= nxt_id;
                     best_fit   <= nxt_fit;
                     cand_count <= nxt_count;
                  end
               end else begin
                  k         <= k + K_W'(1);
                  mem_index <= word_index(k + K_W'(1));
               end
            end

            ST_CLEAR: begin
               if (k == LAST_K) begin
                  state      <= ST_DONE;
                  k          <= '0;
                  mem_index  <= '0;
                  mem_wr_en  <= 1'b0;
                  busy       <= 1'b0;
                  done       <= 1'b1;
                  found      <= w_found;
                  best_id    <= w_id;
                  best_fit   <= w_fit;
                  cand_count <= w_count;
               end else begin
                  k         <= k + K_W'(1);
                  mem_index <= word_index(k + K_W'(1));
               end
            end

            ST_DONE: begin
               state <= ST_IDLE;
            end

            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_candidate_scanner.sv
// Bench for candidate_scanner: directed and randomized banks checked against
// a max-then-first-match reference model, plus latency, clear and reset checks.
module tb_candidate_scanner;

   typedef logic [15:0] bank_t [8];

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic        clear_req;
   logic        busy;
   logic        done;
   logic        found;
   logic [7:0]  best_id;
   logic [7:0]  best_fit;
   logic [3:0]  cand_count;
   logic        mem_wr_en;
   logic [15:0] mem_index;
   logic [15:0] mem_wdata;
   logic [15:0] mem_rdata;

   bank_t bank;
   bank_t preload;
   logic  do_load = 1'b0;
   logic  log_clr = 1'b0;
   int    wr_cnt = 0;
   int    wr_order_err = 0;
   int    exp_idx = 0;
   int    idx_err = 0;

   int checks = 0;
   int failures = 0;

   candidate_scanner dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .clear_req  (clear_req),
      .busy       (busy),
      .done       (done),
      .found      (found),
      .best_id    (best_id),
      .best_fit   (best_fit),
      .cand_count (cand_count),
      .mem_wr_en  (mem_wr_en),
      .mem_index  (mem_index),
      .mem_wdata  (mem_wdata),
      .mem_rdata  (mem_rdata)
   );

   always #5 clk = ~clk;

   // Zero-latency bank plus a write monitor (count, index order, range).
   assign mem_rdata = bank[mem_index[3:1]];

   always @(posedge clk) begin
      if (do_load) bank <= preload;
      else if (mem_wr_en) bank[mem_index[3:1]] <= mem_wdata;
      if (log_clr) begin
         wr_cnt       <= 0;
         wr_order_err <= 0;
         exp_idx      <= 0;
         idx_err      <= 0;
      end else begin
         if (mem_wr_en) begin
            wr_cnt  <= wr_cnt + 1;
            exp_idx <= exp_idx + 2;
            if (mem_index != 16'(exp_idx)) wr_order_err <= wr_order_err + 1;
         end
         if (mem_index > 16'd14) idx_err <= idx_err + 1;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Reference: highest fitness among occupied words, earliest word on ties.
   task automatic model(input bank_t b, output logic f, output logic [7:0] id,
                        output logic [7:0] fit, output int cnt);
      int maxfit;
      maxfit = -1;
      cnt = 0;
      f = 1'b0;
      id = 8'h00;
      fit = 8'h00;
      foreach (b[i]) if (b[i][15:8] != 8'h00) begin
         cnt++;
         if (int'(b[i][7:0]) > maxfit) maxfit = int'(b[i][7:0]);
      end
      for (int i = 0; i < 8; i++) begin
         if (!f && b[i][15:8] != 8'h00 && int'(b[i][7:0]) == maxfit) begin
            f = 1'b1;
            id = b[i][15:8];
            fit = b[i][7:0];
         end
      end
   endtask

   task automatic load_bank(input bank_t b);
      preload = b;
      do_load = 1'b1;
      log_clr = 1'b1;
      @(posedge clk); #1;
      do_load = 1'b0;
      log_clr = 1'b0;
   endtask

   // Start a scan; lat is the cycle index (t+lat) of done, or -1 on timeout.
   task automatic run(input logic clr, input int mid_start, output int lat,
                      output int extra_done, output int unstable, output logic busy_at_done);
      int n;
      logic pf;
      logic [7:0] pi, pfit;
      logic [3:0] pc;
      pf = found; pi = best_id; pfit = best_fit; pc = cand_count;
      unstable = 0;
      start = 1'b1;
      clear_req = clr;
      @(posedge clk); #1;
      start = 1'b0;
      clear_req = 1'b0;
      n = 1;
      while (!done && n < 60) begin
         start = (n == mid_start);
         @(posedge clk); #1;
         n++;
         if (!done && (found !== pf || best_id !== pi || best_fit !== pfit || cand_count !== pc))
            unstable++;
      end
      start = 1'b0;
      lat = done ? n : -1;
      busy_at_done = busy;
      extra_done = 0;
      for (int i = 0; i < 12; i++) begin
         @(posedge clk); #1;
         if (done) extra_done++;
      end
   endtask

   task automatic scan_and_check(input string tag, input bank_t b, input logic clr,
                                 input int mid_start);
      logic ef;
      logic [7:0] eid, efit;
      int ecnt, lat, extra, unstable;
      logic bz;
      model(b, ef, eid, efit, ecnt);
      load_bank(b);
      run(clr, mid_start, lat, extra, unstable, bz);
      chk({tag, " latency"}, 32'(lat), clr ? 32'd17 : 32'd9);
      chk({tag, " found"}, 32'(found), 32'(ef));
      chk({tag, " best_id"}, 32'(best_id), 32'(eid));
      chk({tag, " best_fit"}, 32'(best_fit), 32'(efit));
      chk({tag, " cand_count"}, 32'(cand_count), 32'(ecnt));
      chk({tag, " wr_cnt"}, 32'(wr_cnt), clr ? 32'd8 : 32'd0);
      chk({tag, " extra_done"}, 32'(extra), 32'd0);
      chk({tag, " unstable"}, 32'(unstable), 32'd0);
      chk({tag, " busy_at_done"}, 32'(bz), 32'd0);
      for (int i = 0; i < 8; i++)
         chk({tag, " bank"}, 32'(bank[i]), clr ? 32'd0 : 32'(b[i]));
   endtask

   initial begin
      bank_t b;
      int n;
      rst = 1'b1;
      start = 1'b0;
      clear_req = 1'b0;
      foreach (preload[i]) preload[i] = 16'h0000;
      do_load = 1'b1;
      log_clr = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      do_load = 1'b0;
      log_clr = 1'b0;
      rst = 1'b0;

      chk("reset busy", 32'(busy), 32'd0);
      chk("reset done", 32'(done), 32'd0);
      chk("reset found", 32'(found), 32'd0);
      chk("reset best", 32'({best_id, best_fit}), 32'd0);
      chk("reset count", 32'(cand_count), 32'd0);
      chk("reset wr_en", 32'(mem_wr_en), 32'd0);
      chk("reset index", 32'(mem_index), 32'd0);

      b = '{16'h0510, 16'h0720, 16'h0915, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0};
      scan_and_check("basic", b, 1'b0, 0);
      chk("basic best_id const", 32'(best_id), 32'h07);
      chk("basic count const", 32'(cand_count), 32'd3);

      b = '{16'h0, 16'h0340, 16'h0, 16'h0, 16'h0B40, 16'h0, 16'h0, 16'h0};
      scan_and_check("tie", b, 1'b0, 0);
      chk("tie best const", 32'({best_id, best_fit}), 32'h0340);

      b = '{default: 16'h0};
      scan_and_check("empty", b, 1'b0, 0);

      b = '{16'h0100, 16'h0200, 16'h0300, 16'h0400, 16'h0500, 16'h0600, 16'h0700, 16'h0800};
      scan_and_check("zero_fit", b, 1'b0, 0);
      chk("zero_fit found const", 32'(found), 32'd1);

      b = '{16'h1111, 16'h2222, 16'h3333, 16'h4477, 16'h5544, 16'h6677, 16'h7701, 16'h8802};
      scan_and_check("full_clear", b, 1'b1, 0);
      chk("full_clear wr_order", 32'(wr_order_err), 32'd0);
      chk("full_clear best const", 32'({best_id, best_fit}), 32'h4477);

      b = '{16'h0A10, 16'h0, 16'h0B30, 16'h0, 16'h0C20, 16'h0, 16'h0, 16'h0D05};
      scan_and_check("mid_start", b, 1'b0, 3);

      for (int r = 0; r < 6; r++) begin
         for (int i = 0; i < 8; i++) begin
            b[i][15:8] = ($urandom_range(0, 2) == 0) ? 8'h00 : 8'($urandom_range(1, 255));
            b[i][7:0]  = 8'($urandom_range(0, 7)) << 5;
         end
         scan_and_check("random", b, 1'($urandom_range(0, 1)), 0);
      end

      chk("index range", 32'(idx_err), 32'd0);

      // Reset sampled at the edge that would begin the third clear cycle.
      b = '{16'h1101, 16'h2202, 16'h3303, 16'h4404, 16'h5505, 16'h6606, 16'h7707, 16'h8808};
      load_bank(b);
      start = 1'b1;
      clear_req = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      clear_req = 1'b0;
      for (n = 1; n < 10; n++) begin
         @(posedge clk); #1;
      end
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      chk("rst busy", 32'(busy), 32'd0);
      chk("rst wr_en", 32'(mem_wr_en), 32'd0);
      chk("rst index", 32'(mem_index), 32'd0);
      chk("rst done", 32'(done), 32'd0);
      chk("rst found", 32'(found), 32'd0);
      chk("rst best", 32'({best_id, best_fit}), 32'd0);
      chk("rst count", 32'(cand_count), 32'd0);
      n = 0;
      for (int i = 0; i < 20; i++) begin
         @(posedge clk); #1;
         if (done || mem_wr_en) n++;
      end
      chk("rst quiet", 32'(n), 32'd0);
      chk("rst wr_cnt", 32'(wr_cnt), 32'd2);
      for (int i = 0; i < 8; i++)
         chk("rst bank", 32'(bank[i]), (i < 2) ? 32'd0 : 32'(b[i]));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/candidate_scanner.md
# candidate_scanner

Downstream consumer of the candidate memory bank: on a start pulse it walks every 16-bit candidate word stored in the bank, selects the candidate with the highest fitness, and reports its node ID, fitness and the occupied-entry count. When requested, it then zero-fills the bank so the next collection round starts clean. It is the sole driver of the bank's `index`/`wr_en`/`data_in` ports during a scan.

## Interface
- `WORD_WIDTH`, default 16: candidate word width; bits [15:8] hold the node ID, bits [7:0] hold the unsigned fitness.
- `NUM_WORDS`, default 8: number of candidate words in the bank. Word k sits at byte index 2k. Legal range: 2·NUM_WORDS ≤ 16.
- `EMPTY_ID`, default 8'h00: an ID equal to this value marks an unoccupied entry.
- `clk`, input, 1: the single clock, rising edge. One clock; reset is synchronous and active-high.
- `rst`, input, 1: synchronous, active-high reset.
- `start`, input, 1: single-cycle request; sampled only in IDLE.
- `clear_req`, input, 1: sampled together with `start`; 1 means zero-fill the bank after the scan.
- `busy`, output, 1: high in SCAN and CLEAR.
- `done`, output, 1: one-cycle pulse in DONE.
- `found`, output, 1: at least one occupied entry was seen.
- `best_id`, output, 8: node ID of the winning candidate.
- `best_fit`, output, 8: fitness of the winning candidate.
- `cand_count`, output, $clog2(NUM_WORDS+1): number of occupied entries.
- `mem_wr_en`, output, 1: drives the bank `wr_en`.
- `mem_index`, output, WORD_WIDTH: drives the bank `index`.
- `mem_wdata`, output, WORD_WIDTH: drives the bank `data_in`. Always 16'h0000.
- `mem_rdata`, input, WORD_WIDTH: from the bank `data_out`. Combinational, valid in the same cycle as `mem_index`.

## Operation
- FSM states: IDLE, SCAN, CLEAR, DONE.
- IDLE → SCAN on `start`. The edge that accepts `start` also:
  - latches `clear_req`,
  - zeroes the working count, best and found registers,
  - sets the word counter k to 0.
- SCAN:
  - `mem_index` = 2k, zero-extended; `mem_wr_en` = 0.
  - At each edge, if ID ≠ EMPTY_ID: the count increments. If `found` is still 0, or fitness is strictly greater than the working best, the working best takes this word. Ties therefore keep the lowest index.
  - After k = NUM_WORDS−1: go to CLEAR if `clear_req` was latched, else go to DONE.
- CLEAR:
  - `mem_wr_en` = 1, `mem_index` = 2k, `mem_wdata` = 0, for k = 0..NUM_WORDS−1.
  - Then go to DONE.
- DONE:
  - `done` = 1 for exactly one cycle.
  - The result outputs (`found`, `best_id`, `best_fit`, `cand_count`) load from the working registers on the edge entering DONE.
  - Next state is IDLE.
- Result outputs hold their value until the next DONE; they do not change during a scan.
- If no entry is occupied: `found` = 0, `best_id` = 0, `best_fit` = 0, `cand_count` = 0.
- Fitness 0 with a valid ID is a real candidate: `found` = 1.
- `start` outside IDLE is ignored and not queued.

## Timing
- Reset values: all outputs 0, state IDLE, k = 0, `mem_index` = 0, `mem_wr_en` = 0.
- Let `start` be accepted at edge t.
  - SCAN occupies cycles t+1 .. t+NUM_WORDS.
  - Without clear, `done` is high in cycle t+NUM_WORDS+1.
  - With clear, CLEAR occupies cycles t+NUM_WORDS+1 .. t+2·NUM_WORDS, and `done` is high in cycle t+2·NUM_WORDS+1.
- `busy` is low in DONE. A new `start` is accepted in the first IDLE cycle after DONE.
- `mem_index`, `mem_wr_en` and `mem_wdata` are registered or state-decoded. They must never glitch to an index above 2·(NUM_WORDS−1).
- The write to word k lands at the end of CLEAR cycle k. The bank latency is zero, so no extra wait state is needed.
- Reset mid-operation:
  - IDLE on the next edge; `mem_wr_en` is low from that edge on.
  - A partial clear leaves the bank partially zeroed; this is acceptable.
  - Outputs return to 0 and no `done` is emitted.

## Structure
- Package `cand_pkg` holds:
  - the state enum,
  - `WORD_WIDTH`,
  - ID/fitness slice constants (`CAND_ID_MSB` = 15, `CAND_ID_LSB` = 8, `CAND_FIT_MSB` = 7, `CAND_FIT_LSB` = 0),
  - `EMPTY_ID`.
- No sub-module: the compare-and-update is a few lines. A single module, `candidate_scanner`, is sufficient.

## Test plan
- Bank = {0x0510, 0x0720, 0x0915, 0, 0, 0, 0, 0}, start with `clear_req` = 0 → `done` at t+9. Expected: `found` = 1, `best_id` = 0x07, `best_fit` = 0x20, `cand_count` = 3. Bank is unchanged.
- Tie: words 1 and 4 = {0x0340, 0x0B40} → `best_id` = 0x03, `best_fit` = 0x40.
- Empty bank → `found` = 0, `best_id` = 0, `best_fit` = 0, `cand_count` = 0, `done` at t+9.
- Full bank with `clear_req` = 1 → `done` at t+17. Every bank word reads 0x0000 afterwards. `mem_wr_en` is high for exactly 8 cycles, at indices 0, 2, …, 14 in order.
- `start` pulsed during SCAN → ignored. `done` appears once; results match a single scan.
- `rst` asserted in the 3rd CLEAR cycle → IDLE next cycle; `mem_wr_en` = 0, all outputs 0. Words 0 and 1 are 0x0000, words 2..7 keep their original values.
